// File: rtl/mem_access_unit.sv
// mem_access_unit
// Data-memory access stage between execute and writeback. A load or store
// becomes a single 64-bit request/ack transaction on the data bus. The core is
// stalled for the whole access. Load data is shifted down to its byte lane and
// then zero- or sign-extended. Store data is replicated across every byte lane,
// and the byte strobes select the lanes that are written.
//
// Ports
//   clk, reset              clock; synchronous active-high reset
//   mem_read, mem_write     load / store request levels from control
//   mem_size, mem_signed    access size (byte/half/word/dword), sign-extend loads
//   address, write_data     byte address from the ALU, store data from the register file
//   read_data               extended load data, valid with access_done, then held
//   stall                   holds the PC and pipeline while an access is in flight
//   access_done             one-cycle pulse when the access ends (ok or error)
//   misaligned              one-cycle pulse for an unaligned request (no bus access)
//   bus_error               valid with access_done: timeout or read+write together
//   bus_req/we/addr/wdata/wstrb   data-bus request side, driven only while in BUS
//   bus_rdata, bus_ack      data-bus response side
module mem_access_unit #(
    parameter int WORD_W      = 64,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [1:0]        mem_size,
    input  logic              mem_signed,
    input  logic [WORD_W-1:0] address,
    input  logic [WORD_W-1:0] write_data,
    output logic [WORD_W-1:0] read_data,
    output logic              stall,
    output logic              access_done,
    output logic              misaligned,
    output logic              bus_error,
    output logic              bus_req,
    output logic              bus_we,
    output logic [WORD_W-1:0] bus_addr,
    output logic [WORD_W-1:0] bus_wdata,
    output logic [7:0]        bus_wstrb,
    input  logic [WORD_W-1:0] bus_rdata,
    input  logic              bus_ack
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t              state_r, state_s;
    logic [WORD_W-1:0]   addr_r, wdata_r, read_data_r;
    logic [1:0]          size_r;
    logic                signed_r, we_r, bus_error_r;
    logic [CNT_W-1:0]    cnt_r;
    logic                aligned_s, start_s, capture_s, timeout_s, err_both_s;
    logic                stall_s, misaligned_s, in_bus_s;

    // Shift the addressed lane down to bit 0, then extend it to the full word.
    function automatic logic [63:0] load_extract(input logic [63:0] rdata,
                                                 input logic [2:0]  off,
                                                 input logic [1:0]  size,
                                                 input logic        sgn);
        logic [63:0] lane;
        lane = rdata >> {off, 3'b000};
        case (size)
            2'b00:   load_extract = sgn ? {{56{lane[7]}},  lane[7:0]}  : {56'd0, lane[7:0]};
            2'b01:   load_extract = sgn ? {{48{lane[15]}}, lane[15:0]} : {48'd0, lane[15:0]};
            2'b10:   load_extract = sgn ? {{32{lane[31]}}, lane[31:0]} : {32'd0, lane[31:0]};
            default: load_extract = lane;
        endcase
    endfunction

    // Replicate the low bytes of the store data across all lanes.
    function automatic logic [63:0] store_replicate(input logic [63:0] wd,
                                                    input logic [1:0]  size);
        case (size)
            2'b00:   store_replicate = {8{wd[7:0]}};
            2'b01:   store_replicate = {4{wd[15:0]}};
            2'b10:   store_replicate = {2{wd[31:0]}};
            default: store_replicate = wd;
        endcase
    endfunction

    // Byte enables for the addressed lane(s).
    function automatic logic [7:0] store_strobe(input logic [2:0] off,
                                                input logic [1:0] size);
        case (size)
            2'b00:   store_strobe = 8'h01 << off;
            2'b01:   store_strobe = 8'h03 << off;
            2'b10:   store_strobe = 8'h0F << off;
            default: store_strobe = 8'hFF;
        endcase
    endfunction

    // Alignment check on the live request.
    always_comb begin
        aligned_s = 1'b0;
        case (mem_size)
            2'b00:   aligned_s = 1'b1;
            2'b01:   aligned_s = (address[0] == 1'b0);
            2'b10:   aligned_s = (address[1:0] == 2'b00);
            2'b11:   aligned_s = (address[2:0] == 3'b000);
            default: aligned_s = 1'b0;
        endcase
    end

    // Next-state logic and per-state control strobes.
    always_comb begin
        state_s      = state_r;
        stall_s      = 1'b0;
        misaligned_s = 1'b0;
        start_s      = 1'b0;
        capture_s    = 1'b0;
        timeout_s    = 1'b0;
        err_both_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (mem_read && mem_write) begin
                    // A conflicting request is not sent to the bus; it reports an error.
                    err_both_s = 1'b1;
                    state_s    = ST_DONE;
                end else if ((mem_read || mem_write) && aligned_s) begin
                    stall_s = 1'b1;
                    start_s = 1'b1;
                    state_s = ST_BUS;
                end else if (mem_read || mem_write) begin
                    misaligned_s = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_BUS: begin
                stall_s = 1'b1;
                // If ack arrives in the last allowed cycle, the ack wins over the timeout.
                if (bus_ack) begin
                    capture_s = 1'b1;
                    state_s   = ST_DONE;
                end else if (cnt_r == CNT_W'(TIMEOUT_CYC - 1)) begin
                    timeout_s = 1'b1;
                    state_s   = ST_DONE;
                end else begin
                    state_s = ST_BUS;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State register, latched request, timeout counter and result registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            addr_r      <= '0;
            wdata_r     <= '0;
            size_r      <= 2'b00;
            signed_r    <= 1'b0;
            we_r        <= 1'b0;
            cnt_r       <= '0;
            read_data_r <= '0;
            bus_error_r <= 1'b0;
        end else begin
            state_r <= state_s;
            if (start_s) begin
                addr_r      <= address;
                wdata_r     <= write_data;
                size_r      <= mem_size;
                signed_r    <= mem_signed;
                we_r        <= mem_write;
                cnt_r       <= '0;
                bus_error_r <= 1'b0;
            end else if (state_r == ST_BUS) begin
                cnt_r <= cnt_r + CNT_W'(1);
            end else begin
                cnt_r <= cnt_r;
            end
            if (capture_s) begin
                read_data_r <= load_extract(bus_rdata, addr_r[2:0], size_r, signed_r);
                bus_error_r <= 1'b0;
            end else if (timeout_s || err_both_s) begin
                read_data_r <= '0;
                bus_error_r <= 1'b1;
            end else begin
                read_data_r <= read_data_r;
            end
        end
    end

    assign in_bus_s    = (state_r == ST_BUS);
    assign stall       = stall_s;
    assign misaligned  = misaligned_s;
    assign access_done = (state_r == ST_DONE);
    assign read_data   = read_data_r;
    assign bus_error   = bus_error_r;
    assign bus_req     = in_bus_s;
    assign bus_we      = in_bus_s & we_r;
    assign bus_addr    = in_bus_s ? {addr_r[WORD_W-1:3], 3'b000} : '0;
    assign bus_wdata   = (in_bus_s && we_r) ? store_replicate(wdata_r, size_r) : '0;
    assign bus_wstrb   = (in_bus_s && we_r) ? store_strobe(addr_r[2:0], size_r) : 8'h00;

endmodule
